ev_op_sequencer: RTL and testbench

Sequences the operation-select bus of the EV motor control datapath and shares it between two requesters, PLC and HMI. Each requester asks for an operation code through a req/ack handshake. The block holds each granted opcode stable long enough for the datapath to sample its accel/brake data. It also injects periodic speed-then-PWM refresh pairs and a forced reset sequence when power is dropped. Sits directly upstream of the motor control block and drives its 3-bit operation select.

---
 rtl/ev_ctrl_pkg.sv | 30 +++
 rtl/ev_req_arb2.sv | 44 ++++
 rtl/ev_op_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_ev_op_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ev_ctrl_pkg.sv
// ev_ctrl_pkg: opcodes, FSM states and grant-source encodings shared by the
// EV operation sequencer and its arbiter.
package ev_ctrl_pkg;

   // Datapath operation select codes
   localparam logic [2:0] OP_POWER = 3'b000;  // maintain / no operation
   localparam logic [2:0] OP_HEAD  = 3'b001;
   localparam logic [2:0] OP_HORN  = 3'b010;
   localparam logic [2:0] OP_RIND  = 3'b011;
   localparam logic [2:0] OP_SPEED = 3'b100;
   localparam logic [2:0] OP_PWM   = 3'b101;
   localparam logic [2:0] OP_TEMP  = 3'b110;
   localparam logic [2:0] OP_RESET = 3'b111;

   // Who currently owns op_sel
   localparam logic [1:0] GSRC_NONE = 2'b00;
   localparam logic [1:0] GSRC_PLC  = 2'b01;
   localparam logic [1:0] GSRC_HMI  = 2'b10;
   localparam logic [1:0] GSRC_INT  = 2'b11;  // refresh pair or shutdown

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GRANT    = 3'd1,
      ST_HOLD     = 3'd2,
      ST_AUTO_SPD = 3'd3,
      ST_AUTO_PWM = 3'd4,
      ST_SHUTDOWN = 3'd5
   } state_t;

endpackage

// File: rtl/ev_req_arb2.sv
// ev_req_arb2: two-way PLC/HMI arbiter. A lone requester always wins; on a
// collision a starved source wins, otherwise mode_i picks the priority side.
module ev_req_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,   // bit0 PLC, bit1 HMI
   input  logic       mode_i,  // 0: PLC priority, 1: HMI priority
   input  logic       upd_i,   // commit the current decision to the flags
   output logic [1:0] win_o    // one-hot winner, bit0 PLC, bit1 HMI
);

   logic [1:0] starve_q, starve_d;

   // Winner selection from requests, starvation flags and mode
   always_comb begin
      win_o = 2'b00;
      unique case (req_i)
         2'b01: win_o = 2'b01;
         2'b10: win_o = 2'b10;
         2'b11: begin
            if (starve_q == 2'b01)      win_o = 2'b01;
            else if (starve_q == 2'b10) win_o = 2'b10;
            else                        win_o = mode_i ? 2'b10 : 2'b01;
         end
         default: win_o = 2'b00;
      endcase
   end

   // Flag update: winner clears its own flag, collision loser sets its flag
   always_comb begin
      starve_d = starve_q;
      if (upd_i) begin
         starve_d = starve_q & ~win_o;
         if (req_i == 2'b11) starve_d = starve_d | ~win_o;
      end
   end

   // Starvation flag register
   always_ff @(posedge clk_i) begin
      if (rst_i) starve_q <= 2'b00;
      else       starve_q <= starve_d;
   end

endmodule

// File: rtl/ev_op_sequencer.sv
// ev_op_sequencer: owns the 3-bit operation select of the motor datapath.
// Arbitrates PLC/HMI opcode requests, holds each opcode for HOLD_CYCLES,
// injects speed->PWM refresh pairs and a forced reset sequence on power loss.
//
// Handshake (both requesters): req and op are held until a one-cycle ack;
// the requester drops req after seeing ack. ack with reject=1 means refused
// (power off). The opcode sampled in the IDLE decision cycle is the one used.
// A source whose ack is currently high is masked so the same request is
// never answered twice.
module ev_op_sequencer
   import ev_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES = 8,
   parameter int REFRESH_DIV = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       power_on,
   input  logic       temp_fault,
   input  logic       mode_select,
   input  logic       plc_req,
   input  logic [2:0] plc_op,
   output logic       plc_ack,
   input  logic       hmi_req,
   input  logic [2:0] hmi_op,
   output logic       hmi_ack,
   output logic       reject,
   output logic [2:0] op_sel,
   output logic       op_valid,
   output logic       busy,
   output logic [1:0] grant_src,
   output state_t     dbg_state   // FSM state for checkers
);

   localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam int RW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    op_sel_q, op_sel_d, lat_op_q, lat_op_d;
   logic          op_valid_q, op_valid_d;
   logic          plc_ack_q, plc_ack_d, hmi_ack_q, hmi_ack_d;
   logic          reject_q, reject_d;
   logic [1:0]    gsrc_q, gsrc_d;
   logic [1:0]    lat_req_q, lat_req_d;
   logic          lat_mode_q, lat_mode_d;
   logic [RW-1:0] ref_cnt_q, ref_cnt_d;
   logic          refresh_pend_q, refresh_pend_d;
   logic          temp_q;
   logic [1:0]    req_m, arb_req, win;
   logic          arb_mode, arb_upd;
   logic          pwm_entry, temp_rise, refresh_wrap;

   assign req_m    = {hmi_req & ~hmi_ack_q, plc_req & ~plc_ack_q};
   // In GRANT the arbiter re-sees the decision latched in IDLE so the flags
   // are updated for exactly that decision.
   assign arb_req  = (state_q == ST_GRANT) ? lat_req_q  : req_m;
   assign arb_mode = (state_q == ST_GRANT) ? lat_mode_q : mode_select;
   assign arb_upd  = ena & (state_q == ST_GRANT);

   ev_req_arb2 u_arb (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (arb_req),
      .mode_i (arb_mode),
      .upd_i  (arb_upd),
      .win_o  (win)
   );

   // Refresh timer and pending flag; a fresh request beats a same-cycle clear
   always_comb begin
      temp_rise    = temp_fault & ~temp_q;
      refresh_wrap = 1'b0;
      ref_cnt_d    = ref_cnt_q;
      if (!power_on) begin
         ref_cnt_d = '0;
      end else if (ref_cnt_q == REF_LAST) begin
         ref_cnt_d    = '0;
         refresh_wrap = 1'b1;
      end else begin
         ref_cnt_d = ref_cnt_q + RW'(1);
      end
      refresh_pend_d = refresh_pend_q;
      if (refresh_wrap || temp_rise) refresh_pend_d = 1'b1;
      else if (pwm_entry)            refresh_pend_d = 1'b0;
   end

   // FSM next state and registered-output next values
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_sel_d   = op_sel_q;
      op_valid_d = op_valid_q;
      gsrc_d     = gsrc_q;
      lat_op_d   = lat_op_q;
      lat_req_d  = lat_req_q;
      lat_mode_d = lat_mode_q;
      plc_ack_d  = 1'b0;
      hmi_ack_d  = 1'b0;
      reject_d   = 1'b0;
      pwm_entry  = 1'b0;

      if (!power_on && state_q != ST_IDLE && state_q != ST_SHUTDOWN) begin
         // Power loss aborts any activity; the aborted hold never acks
         state_d    = ST_SHUTDOWN;
         cnt_d      = HOLD_LAST;
         op_sel_d   = OP_RESET;
         op_valid_d = 1'b1;
         gsrc_d     = GSRC_INT;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!power_on) begin
                  if (req_m[0]) begin
                     plc_ack_d = 1'b1;
                     reject_d  = 1'b1;
                  end else if (req_m[1]) begin
                     hmi_ack_d = 1'b1;
                     reject_d  = 1'b1;
                  end
               end else if (refresh_pend_q) begin
                  state_d    = ST_AUTO_SPD;
                  cnt_d      = HOLD_LAST;
                  op_sel_d   = OP_SPEED;
                  op_valid_d = 1'b1;
                  gsrc_d     = GSRC_INT;
               end else if (|req_m) begin
                  state_d    = ST_GRANT;
                  lat_req_d  = req_m;
                  lat_mode_d = mode_select;
                  if (win[0]) begin
                     plc_ack_d = 1'b1;
                     lat_op_d  = plc_op;
                     gsrc_d    = GSRC_PLC;
                  end else begin
                     hmi_ack_d = 1'b1;
                     lat_op_d  = hmi_op;
                     gsrc_d    = GSRC_HMI;
                  end
               end
            end
            ST_GRANT: begin
               if (lat_op_q == OP_POWER) begin
                  state_d = ST_IDLE;
                  gsrc_d  = GSRC_NONE;
               end else begin
                  state_d    = ST_HOLD;
                  cnt_d      = HOLD_LAST;
                  op_sel_d   = lat_op_q;
                  op_valid_d = 1'b1;
               end
            end
            ST_HOLD, ST_AUTO_SPD: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
               end else if (state_q == ST_AUTO_SPD || lat_op_q == OP_SPEED) begin
                  // A speed update always propagates to PWM
                  state_d    = ST_AUTO_PWM;
                  cnt_d      = HOLD_LAST;
                  op_sel_d   = OP_PWM;
                  op_valid_d = 1'b1;
                  gsrc_d     = GSRC_INT;
                  pwm_entry  = 1'b1;
               end else begin
                  state_d    = ST_IDLE;
                  op_sel_d   = OP_POWER;
                  op_valid_d = 1'b0;
                  gsrc_d     = GSRC_NONE;
               end
            end
            ST_AUTO_PWM, ST_SHUTDOWN: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
               end else begin
                  state_d    = ST_IDLE;
                  op_sel_d   = OP_POWER;
                  op_valid_d = 1'b0;
                  gsrc_d     = GSRC_NONE;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               op_sel_d   = OP_POWER;
               op_valid_d = 1'b0;
               gsrc_d     = GSRC_NONE;
            end
         endcase
      end
   end

   // State registers; ena low freezes everything, rst overrides ena
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         op_sel_q       <= OP_POWER;
         op_valid_q     <= 1'b0;
         plc_ack_q      <= 1'b0;
         hmi_ack_q      <= 1'b0;
         reject_q       <= 1'b0;
         gsrc_q         <= GSRC_NONE;
         lat_op_q       <= OP_POWER;
         lat_req_q      <= 2'b00;
         lat_mode_q     <= 1'b0;
         ref_cnt_q      <= '0;
         refresh_pend_q <= 1'b0;
         temp_q         <= 1'b0;
      end else if (ena) begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         op_sel_q       <= op_sel_d;
         op_valid_q     <= op_valid_d;
         plc_ack_q      <= plc_ack_d;
         hmi_ack_q      <= hmi_ack_d;
         reject_q       <= reject_d;
         gsrc_q         <= gsrc_d;
         lat_op_q       <= lat_op_d;
         lat_req_q      <= lat_req_d;
         lat_mode_q     <= lat_mode_d;
         ref_cnt_q      <= ref_cnt_d;
         refresh_pend_q <= refresh_pend_d;
         temp_q         <= temp_fault;
      end
   end

   assign plc_ack   = plc_ack_q;
   assign hmi_ack   = hmi_ack_q;
   assign reject    = reject_q;
   assign op_sel    = op_sel_q;
   assign op_valid  = op_valid_q;
   assign grant_src = gsrc_q;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ev_op_sequencer.sv
// tb_ev_op_sequencer: directed bench for the EV operation sequencer with
// HOLD_CYCLES=4 and REFRESH_DIV=64. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_ev_op_sequencer;
   import ev_ctrl_pkg::*;

   localparam int HC = 4;
   localparam int RD = 64;

   logic       clk = 1'b0;
   logic       rst, ena, power_on, temp_fault, mode_select;
   logic       plc_req, hmi_req;
   logic [2:0] plc_op, hmi_op;
   logic       plc_ack, hmi_ack, reject, op_valid, busy;
   logic [2:0] op_sel;
   logic [1:0] grant_src;
   state_t     dbg_state;

   int total = 0;
   int bad   = 0;
   logic [4:0] exp_q[$];   // expected {grant_src, op_sel} per held cycle

   // Clock
   always #5 clk = ~clk;

   ev_op_sequencer #(.HOLD_CYCLES(HC), .REFRESH_DIV(RD)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .power_on    (power_on),
      .temp_fault  (temp_fault),
      .mode_select (mode_select),
      .plc_req     (plc_req),
      .plc_op      (plc_op),
      .plc_ack     (plc_ack),
      .hmi_req     (hmi_req),
      .hmi_op      (hmi_op),
      .hmi_ack     (hmi_ack),
      .reject      (reject),
      .op_sel      (op_sel),
      .op_valid    (op_valid),
      .busy        (busy),
      .grant_src   (grant_src),
      .dbg_state   (dbg_state)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_out"}, 16'({op_sel, op_valid, busy, grant_src, plc_ack, hmi_ack, reject}), 16'h0);
      check_eq({tag, "_st"}, 16'(dbg_state), 16'(ST_IDLE));
   endtask

   task automatic check_ack(input string tag, input logic p, input logic h, input logic r,
                            input logic [1:0] g);
      check_eq(tag, 16'({plc_ack, hmi_ack, reject, grant_src}), 16'({p, h, r, g}));
   endtask

   // Expect op/gsrc held for n cycles with no handshake activity
   task automatic hold_check(input string tag, input logic [2:0] op, input logic [1:0] gsrc,
                             input int n);
      logic [4:0] e;
      for (int i = 0; i < n; i++) exp_q.push_back({gsrc, op});
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check_eq(tag, 16'({grant_src, op_sel}), 16'(e));
         check_eq({tag, "_fl"}, 16'({op_valid, busy, plc_ack, hmi_ack, reject}), 16'(5'b11000));
      end
   endtask

   // Restart the refresh timer from zero
   task automatic power_cycle();
      power_on = 1'b0;
      tick();
      power_on = 1'b1;
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ena = 1'b1; power_on = 1'b0; temp_fault = 1'b0; mode_select = 1'b0;
      plc_req = 1'b0; hmi_req = 1'b0; plc_op = OP_POWER; hmi_op = OP_POWER;
      tick();
      tick();
      check_idle("reset");
      rst = 1'b0;

      // Single PLC request, 1-cycle ack latency, 4-cycle hold
      power_on = 1'b1; plc_req = 1'b1; plc_op = OP_HEAD;
      tick();
      check_ack("t1_ack", 1'b1, 1'b0, 1'b0, GSRC_PLC);
      check_eq("t1_grant_op", 16'({op_sel, op_valid, busy}), 16'({OP_POWER, 1'b0, 1'b1}));
      plc_req = 1'b0;
      hold_check("t1_hold", OP_HEAD, GSRC_PLC, HC);
      tick();
      check_idle("t1_end");

      // Opcode 000: acked, no hold
      power_cycle();
      plc_req = 1'b1; plc_op = OP_POWER;
      tick();
      check_ack("t1b_ack", 1'b1, 1'b0, 1'b0, GSRC_PLC);
      plc_req = 1'b0;
      tick();
      check_idle("t1b_end");

      // Collision, mode=1: HMI first, then starved PLC, then starved HMI
      power_cycle();
      mode_select = 1'b1;
      plc_req = 1'b1; plc_op = OP_HORN;
      hmi_req = 1'b1; hmi_op = OP_RIND;
      tick();
      check_ack("t2_hmi_first", 1'b0, 1'b1, 1'b0, GSRC_HMI);
      hmi_req = 1'b0;
      hold_check("t2_hold_hmi", OP_RIND, GSRC_HMI, 1);
      hmi_req = 1'b1;
      hold_check("t2_hold_hmi", OP_RIND, GSRC_HMI, HC - 1);
      tick();
      check_idle("t2_gap1");
      tick();
      check_ack("t2_plc_starved", 1'b1, 1'b0, 1'b0, GSRC_PLC);
      plc_req = 1'b0; mode_select = 1'b0;
      hold_check("t2_hold_plc", OP_HORN, GSRC_PLC, 1);
      plc_req = 1'b1;
      hold_check("t2_hold_plc", OP_HORN, GSRC_PLC, HC - 1);
      tick();
      check_idle("t2_gap2");
      tick();
      check_ack("t2_hmi_starved", 1'b0, 1'b1, 1'b0, GSRC_HMI);
      hmi_req = 1'b0;
      hold_check("t2_hold_hmi2", OP_RIND, GSRC_HMI, HC);
      tick();
      check_idle("t2_gap3");
      tick();
      check_ack("t2_plc_last", 1'b1, 1'b0, 1'b0, GSRC_PLC);
      plc_req = 1'b0;
      hold_check("t2_hold_plc2", OP_HORN, GSRC_PLC, HC);
      tick();
      check_idle("t2_end");

      // Speed request chains into PWM with a single ack
      power_cycle();
      hmi_req = 1'b1; hmi_op = OP_SPEED;
      tick();
      check_ack("t3_ack", 1'b0, 1'b1, 1'b0, GSRC_HMI);
      hmi_req = 1'b0;
      hold_check("t3_speed", OP_SPEED, GSRC_HMI, HC);
      hold_check("t3_pwm", OP_PWM, GSRC_INT, HC);
      tick();
      check_idle("t3_end");

      // Power drop in the second hold cycle -> shutdown sequence
      power_cycle();
      plc_req = 1'b1; plc_op = OP_HEAD;
      tick();
      check_ack("t4_ack", 1'b1, 1'b0, 1'b0, GSRC_PLC);
      plc_req = 1'b0;
      hold_check("t4_hold", OP_HEAD, GSRC_PLC, 2);
      power_on = 1'b0;
      hold_check("t4_shutdown", OP_RESET, GSRC_INT, HC);
      tick();
      check_idle("t4_end");
      plc_req = 1'b1; plc_op = OP_HORN;
      tick();
      check_ack("t4_reject", 1'b1, 1'b0, 1'b1, GSRC_NONE);
      check_eq("t4_reject_nohold", 16'({op_sel, op_valid, busy}), 16'h0);
      plc_req = 1'b0;
      tick();
      check_idle("t4_after_reject");
      plc_req = 1'b1; hmi_req = 1'b1;
      tick();
      check_ack("t4_rej_plc", 1'b1, 1'b0, 1'b1, GSRC_NONE);
      plc_req = 1'b0;
      tick();
      check_ack("t4_rej_hmi", 1'b0, 1'b1, 1'b1, GSRC_NONE);
      hmi_req = 1'b0;
      tick();
      check_idle("t4_rej_end");

      // Periodic refresh after 64 powered cycles
      power_on = 1'b1;
      for (int i = 0; i < RD; i++) begin
         tick();
         check_eq("t5_quiet", 16'(busy), 16'h0);
      end
      hold_check("t5_speed", OP_SPEED, GSRC_INT, HC);
      hold_check("t5_pwm", OP_PWM, GSRC_INT, HC);
      tick();
      check_idle("t5_end");

      // temp_fault rising edge triggers the refresh pair at once
      tick();
      tick();
      temp_fault = 1'b1;
      tick();
      check_idle("t5_temp_edge");
      hold_check("t5_temp_speed", OP_SPEED, GSRC_INT, HC);
      hold_check("t5_temp_pwm", OP_PWM, GSRC_INT, HC);
      tick();
      check_idle("t5_temp_end");
      temp_fault = 1'b0;

      // ena low freezes a hold in progress; the hold resumes afterwards
      power_cycle();
      plc_req = 1'b1; plc_op = OP_RIND;
      tick();
      check_ack("t6_ack", 1'b1, 1'b0, 1'b0, GSRC_PLC);
      plc_req = 1'b0;
      hold_check("t6_hold", OP_RIND, GSRC_PLC, 2);
      ena = 1'b0;
      hold_check("t6_frozen", OP_RIND, GSRC_PLC, 10);
      ena = 1'b1;
      hold_check("t6_resume", OP_RIND, GSRC_PLC, 2);
      tick();
      check_idle("t6_end");

      // rst wins over ena=0
      power_cycle();
      plc_req = 1'b1; plc_op = OP_HEAD;
      tick();
      check_ack("t7_ack", 1'b1, 1'b0, 1'b0, GSRC_PLC);
      plc_req = 1'b0;
      hold_check("t7_hold", OP_HEAD, GSRC_PLC, 1);
      ena = 1'b0; rst = 1'b1;
      tick();
      check_idle("t7_reset");
      rst = 1'b0; ena = 1'b1;
      tick();
      check_idle("t7_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
